// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding (also used by the transmitter).
package uart_pkg;

   localparam logic [13:0] BIT_TIMER_MAX = 14'd10416;
   localparam logic [13:0] HALF_BIT      = BIT_TIMER_MAX / 2;
   localparam int unsigned DATA_BITS     = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StWaitIdle
   } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-side UART signal bundle: serial line in, byte/strobe/status out.
interface uart_receiver_if;
   import uart_pkg::*;

   logic                 uart_rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_busy;
   logic                 frame_err;
   logic                 parity_err;

   modport master (
      output uart_rx,
      input  rx_data, rx_valid, rx_busy, frame_err, parity_err
   );

   modport slave (
      input  uart_rx,
      output rx_data, rx_valid, rx_busy, frame_err, parity_err
   );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; synchronous active-low reset.
module sync_2ff #(
   parameter int unsigned     Width    = 1,
   parameter logic [Width-1:0] ResetVal = '1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q, sync_q;

   // Two back-to-back capture stages.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and one-cycle result strobes.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_receiver import uart_pkg::*; #(
   parameter logic [13:0] BitTimerMax = BIT_TIMER_MAX,
   parameter logic [13:0] HalfBit     = BitTimerMax / 2
) (
   input  logic            clk,
   input  logic            rst_n,
   uart_receiver_if.slave  rx_if
);

   localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [13:0]          timer_q, timer_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 perr_q, perr_d;
`endif

   sync_2ff #(
      .Width    (1),
      .ResetVal (1'b1)
   ) u_rx_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (rx_if.uart_rx),
      .q_o    (rx_s)
   );

   // Next-state, timer and datapath decisions from the synchronized line.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 14'd1;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      perr_d    = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            timer_d = '0;
            if (!rx_s) state_d = StStart;
         end
         StStart: begin
            if (timer_q == HalfBit) begin
               timer_d = '0;
               // A line that is high again at mid-start was a glitch.
               if (!rx_s) begin
                  state_d   = StData;
                  bit_cnt_d = '0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (timer_q == BitTimerMax) begin
               timer_d   = '0;
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
         StParity: begin
`ifdef UART_RX_PARITY_EN
            if (timer_q == BitTimerMax) begin
               timer_d   = '0;
               par_bad_d = rx_s ^ (^shift_q);
               state_d   = StStop;
            end
`else
            state_d = StIdle;
`endif
         end
         StStop: begin
            if (timer_q == BitTimerMax) begin
               timer_d = '0;
               if (rx_s) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_bad_q;
`endif
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            // Hold through a break until the line returns high.
            timer_d = '0;
            if (rx_s) state_d = StIdle;
         end
         default: begin
            timer_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         perr_q    <= perr_d;
`endif
      end
   end

   assign rx_if.rx_data   = data_q;
   assign rx_if.rx_valid  = valid_q;
   assign rx_if.rx_busy   = (state_q != StIdle);
   assign rx_if.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_err = perr_q;
`else
   assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed + randomized bench for uart_receiver with a 16-clock bit period.
module tb_uart_receiver;

   localparam int Bit = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_receiver_if bus ();

   uart_receiver #(
      .BitTimerMax (14'd15),
      .HalfBit     (14'd7)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (bus)
   );

   int n_assert = 0;
   int n_fail = 0;

   // Reference model: bytes that must appear, in order, and last good byte.
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;
   int         exp_ferr = 0;
   int         exp_perr = 0;

   // Observations gathered away from the active edge.
   logic [7:0] got_q[$];
   int ferr_n = 0, perr_n = 0, perr_with_valid = 0, clash_n = 0;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.rx_valid === 1'b1) begin
            got_q.push_back(bus.rx_data);
            if (bus.parity_err === 1'b1) perr_with_valid++;
         end
         if (bus.frame_err === 1'b1) ferr_n++;
         if (bus.parity_err === 1'b1) perr_n++;
         if (bus.rx_valid === 1'b1 && bus.frame_err === 1'b1) clash_n++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      bus.uart_rx = b;
      wait_clks(Bit);
   endtask

   // Full frame; parity bit is inserted only in the parity build.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ bad_par);
`endif
      if (bad_par) exp_perr++;
      drive_bit(stop_bit);
      if (stop_bit) begin
         exp_q.push_back(d);
         last_good = d;
      end else begin
         exp_ferr++;
      end
   endtask

   task automatic check_stream(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check({tag, "_byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
      end
      check({tag, "_ferr"}, ferr_n, exp_ferr);
      check({tag, "_rx_data"}, {24'h0, bus.rx_data}, {24'h0, last_good});
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] pat;
      bus.uart_rx = 1'b1;

      // Reset state.
      wait_clks(4);
      check("rst_rx_data", {24'h0, bus.rx_data}, 32'h0);
      check("rst_rx_valid", {31'h0, bus.rx_valid}, 32'h0);
      check("rst_rx_busy", {31'h0, bus.rx_busy}, 32'h0);
      check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
      check("rst_parity_err", {31'h0, bus.parity_err}, 32'h0);
      rst_n = 1'b1;
      wait_clks(10);

      // Single clean frame.
      send_frame(8'hA5, 1'b1, 1'b0);
      wait_clks(Bit);
      check_stream("a5");
      check("a5_busy_after", {31'h0, bus.rx_busy}, 32'h0);

      // Back-to-back frames without an idle gap.
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      wait_clks(Bit);
      check_stream("b2b");

      // Short low glitch is rejected at the start-bit mid-point.
      bus.uart_rx = 1'b0;
      wait_clks(3);
      bus.uart_rx = 1'b1;
      wait_clks(Bit);
      check("glitch_busy", {31'h0, bus.rx_busy}, 32'h0);
      check_stream("glitch");

      // Framing error: stop bit low and line held low 40 clocks in total.
      send_frame(8'h3C, 1'b0, 1'b0);
      bus.uart_rx = 1'b0;
      wait_clks(40 - Bit);
      check("ferr_busy_held", {31'h0, bus.rx_busy}, 32'h1);
      check_stream("ferr");
      bus.uart_rx = 1'b1;
      wait_clks(8);
      check("ferr_busy_released", {31'h0, bus.rx_busy}, 32'h0);

      // Reset during the 4th data bit of 0x5A, then a clean 0x81.
      pat = 8'h5A;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(pat[i]);
      bus.uart_rx = pat[3];
      wait_clks(Bit / 2);
      rst_n = 1'b0;
      bus.uart_rx = 1'b1;
      wait_clks(3);
      check("midrst_busy", {31'h0, bus.rx_busy}, 32'h0);
      last_good = 8'h00;
      rst_n = 1'b1;
      wait_clks(3 * Bit);
      check_stream("midrst");
      send_frame(8'h81, 1'b1, 1'b0);
      wait_clks(Bit);
      check_stream("after_rst");

`ifdef UART_RX_PARITY_EN
      // Wrong parity still delivers the byte, with a parity strobe.
      send_frame(8'h07, 1'b1, 1'b1);
      wait_clks(Bit);
      check_stream("par_bad");
`endif

      // Loopback-style byte and randomized back-to-back traffic.
      send_frame(8'h4D, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b1, 1'b0);
      end
      wait_clks(2 * Bit);
      check_stream("random");
      check("busy_final", {31'h0, bus.rx_busy}, 32'h0);

      check("valid_ferr_clash", clash_n, 0);
      check("parity_err_count", perr_n, exp_perr);
      check("parity_with_valid", perr_with_valid, exp_perr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Asynchronous UART receiver, 8N1 at 9600 baud from a 100 MHz clock.
- Counterpart of the team's UART transmitter: frames are 1 start bit (0), 8 data bits LSB-first and 1 stop bit (1).
- Takes the serial `uart_rx` pin and delivers each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the core's memory-mapped UART/IO logic.

Parameters:
- BIT_TIMER_MAX, 14'd10416: bit-timer reload; one bit period = BIT_TIMER_MAX+1 clocks.
- HALF_BIT, BIT_TIMER_MAX/2: start-bit mid-point offset in clocks.
- DATA_BITS, 8: data bits per frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- uart_rx  in  1  asynchronous serial input; idles high.
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_busy  out  1  high while a frame is in progress.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled 0.
- parity_err  out  1  one-cycle pulse on parity mismatch; tied 0 unless UART_RX_PARITY_EN is defined.
- Interface decision: one clock; reset is synchronous and active-low.

Behaviour:
- **Reset** (rst_n=0 at posedge clk):
  - state=IDLE; timer=0; bit count=0; shift register=0.
  - Synchronizer flops=1.
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, parity_err=0.
  - Reset mid-frame abandons the frame; no strobe is produced.
- **Input synchronization:** uart_rx passes through a 2-flop synchronizer, giving rx_s. All decisions use rx_s only.
- **Timer:** 14-bit counter.
  - Cleared in IDLE and on every state change or sample point.
  - Otherwise increments by 1 each clock.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - rx_busy = (state != IDLE).
- **IDLE:** rx_s==0 moves to START.
- **START:**
  - At timer==HALF_BIT, sample rx_s.
  - rx_s==0: go to DATA with bit count 0.
  - rx_s==1: glitch; return to IDLE with no strobes.
- **DATA:**
  - At each timer==BIT_TIMER_MAX, shift rx_s in at MSB (shift right), so the first bit received ends at bit 0.
  - Increment the bit count.
  - After the 8th sample, go to STOP. With UART_RX_PARITY_EN defined, go to PARITY instead.
- **STOP:** at timer==BIT_TIMER_MAX, sample rx_s.
  - rx_s==1: rx_data<=shift register; rx_valid=1 for exactly the next cycle; go to IDLE.
  - rx_s==0: frame_err=1 for one cycle; rx_data unchanged; rx_valid stays 0; go to WAIT_IDLE.
- **WAIT_IDLE:** hold until rx_s==1, then go to IDLE. This prevents break conditions from retriggering.
- **Latency:** rx_valid asserts 2 + 1 + HALF_BIT + 9*(BIT_TIMER_MAX+1) + 1 clocks after the uart_rx falling edge, ±1 clock of sampling phase.
- **Strobes and back-to-back frames:**
  - rx_valid and frame_err are never high in the same cycle.
  - A start edge in the cycle after STOP→IDLE is accepted, so there is no dead time beyond the half stop bit.
- **Output hold:** rx_data holds its value until the next valid frame. There is no ready/backpressure; the consumer must capture on rx_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- **Defined:**
  - Adds a PARITY state between DATA and STOP.
  - One even-parity bit is sampled at BIT_TIMER_MAX.
  - On mismatch, parity_err pulses 1 cycle, in the same cycle rx_valid would have pulsed. rx_data is still updated and rx_valid still pulses.
  - A framing error takes precedence: only frame_err pulses, and parity_err is suppressed.
  - Frame length becomes 11 bits.
- **Undefined:** 8N1 only; parity_err constant 0.

Decomposition:
- **Shared package uart_pkg:**
  - BIT_TIMER_MAX and HALF_BIT constants.
  - DATA_BITS.
  - The rx state typedef/encoding.
  - This package is shared with the transmitter's constants.
- **Sub-module sync_2ff:** the natural sub-module; a generic 2-flop synchronizer, reset value 1, reusable for other async pins. The receiver instantiates it for uart_rx.

Test Plan:
All tests use BIT_TIMER_MAX=15 and HALF_BIT=7.
- Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → rx_valid one cycle, rx_data=0xA5, frame_err=0, rx_busy low after.
- Back-to-back frames 0x00 then 0xFF, no idle gap → two rx_valid pulses, rx_data 0x00 then 0xFF.
- Low glitch of 3 clocks on uart_rx → no rx_valid, no frame_err; rx_busy returns 0 by START mid-point.
- Frame 0x3C with stop bit=0 and line held low 40 clocks → frame_err single pulse, rx_data keeps its previous value; rx_busy stays high until line high.
- rst_n low during the 4th data bit of 0x5A, then a clean 0x81 → no output for 0x5A, then rx_data=0x81 with a single rx_valid.
- With UART_RX_PARITY_EN: 0x07 with parity bit 0 (wrong) → rx_valid and parity_err pulse together, rx_data=0x07. Loopback from the transmitter of 0x4D → rx_data=0x4D.
